ram_scan_ctrl: RTL and testbench
================================

# ram_scan_ctrl

Parametrised dual-port RAM with an autonomous scan engine for board-level memory inspection. Holds 2^ADDR_W words of DATA_W bits and has a synchronous write port driven from switches/keys. A read address sweeps the array on a programmable tick: up, down, held, or manually addressed. A lap flag toggles on every wrap, and a clear sequencer zero-fills the array. Its outputs (address, data, lap) feed the existing hex display decoders directly.

## Interface
- DATA_W, 4, word width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- TICK_DIV, 12500000, CLOCK_50 cycles per scan step (250 ms); must be ≥ 2
- CLOCK_50  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- mode  in  2  00 scan up, 01 scan down, 10 hold, 11 manual
- man_addr  in  ADDR_W  read address used in manual mode
- wr_en  in  1  write strobe, one write per cycle while high
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  start zero-fill; level, sampled in IDLE only
- rd_addr  out  ADDR_W  current read address
- rd_data  out  DATA_W  registered contents of mem[rd_addr]
- lap  out  1  toggles on each scan wrap
- tick  out  1  one-cycle pulse per scan step
- busy  out  1  high while clear sequence runs

## Operation
- Reset values: rd_addr=0, rd_data=0, lap=0, tick=0, busy=0, tick counter=0, FSM=IDLE. The memory array is not reset.
- Tick divider:
  - Counts 0..TICK_DIV-1 continuously in every mode and state.
  - tick=1 for the one cycle in which the count equals TICK_DIV-1, then the count returns to 0.
- Scan, applied on the cycle where tick=1:
  - up: rd_addr+1. Wrap 2^ADDR_W-1 -> 0 toggles lap.
  - down: rd_addr-1. Wrap 0 -> 2^ADDR_W-1 toggles lap.
  - hold: rd_addr and lap unchanged.
  - manual: every cycle, regardless of tick, rd_addr <= man_addr; lap unchanged.
- Mode change takes effect on the next edge. Leaving manual resumes scanning from the last loaded man_addr.
- Read: rd_data <= mem[rd_addr] every cycle. Read-during-write to the same address returns the old data.
- Write: in IDLE, when wr_en=1, mem[wr_addr] <= wr_data.
- Clear FSM:
  - IDLE: clr_req=1 -> CLEAR, busy=1, clear pointer=0.
  - CLEAR: writes 0 to mem[pointer], then pointer+1. After writing 2^ADDR_W-1, returns to IDLE with busy=0.
  - Total CLEAR duration is exactly 2^ADDR_W cycles.
  - wr_en is ignored (dropped, not queued) during CLEAR.
  - Scanning and reads continue during CLEAR.
  - clr_req still high on return to IDLE starts a new clear on the next edge.
- Reset asserted mid-CLEAR aborts it. Array contents are then partially cleared; this is legal.

## Timing
- rd_addr updates on the edge where tick=1; rd_data reflects the new address one edge later.
- A write at edge t is visible on rd_data at edge t+2 when rd_addr==wr_addr.
- Manual mode: man_addr change -> rd_addr at +1 edge, rd_data at +2.
- lap changes on the same edge as the wrapping rd_addr update.
- busy rises on the edge after clr_req is sampled, and falls on the edge that writes the last word.
- Reset asserts asynchronously at any time. Release requires no synchronisation inside the block.

## Test plan
- TICK_DIV=4, ADDR_W=5, mode=00 from reset: tick on cycles 3, 7, 11…; rd_addr 0 -> 1 -> 2. After 32 ticks rd_addr=0 and lap=1; after 64 ticks lap=0.
- Write 0xA to address 7 (single wr_en cycle), then mode=11, man_addr=7: rd_addr=7 at +1 edge, rd_data=0xA at +2.
- Mode=01 from rd_addr=0: first tick gives rd_addr=31 and lap toggles. Mode=10 for 10 ticks: rd_addr stays 31, tick still pulses.
- Manual mode with rd_addr=5, write 0x3 to address 5: rd_data holds the old value at t+1 and shows 0x3 at t+2.
- Fill all 32 words with 0xF, pulse clr_req: busy high for exactly 32 cycles; a wr_en of 0x9 to address 3 mid-clear is dropped. Afterwards a manual scan of every address reads 0.
- Assert reset at clear pointer=10: all outputs take reset values immediately, FSM=IDLE, addresses 0-9 read 0 and addresses 10-31 read 0xF.

Source files
------------

// File: rtl/ram_scan_ctrl.sv
// Dual-port scan RAM: synchronous write port, a tick-paced read-address sweep
// (up/down/hold/manual) with a lap flag, and a zero-fill clear sequencer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | external writes accepted, clr_req sampled
// S_CLEAR | one zero written per cycle at clr_ptr, external writes dropped
module ram_scan_ctrl #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 12500000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] man_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              lap,
  output logic              tick,
  output logic              busy
);

  localparam int                CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam int                DEPTH     = 1 << ADDR_W;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] clr_ptr, next_ptr;
  logic [CNT_W-1:0]  tick_cnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  assign tick = (tick_cnt == CNT_LAST);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Manual mode loads every cycle so leaving it resumes from the last man_addr.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
      lap     <= 1'b0;
    end else begin
      case (mode)
        2'b00: if (tick) begin
          rd_addr <= rd_addr + 1'b1;
          if (rd_addr == ADDR_LAST) lap <= ~lap;
        end
        2'b01: if (tick) begin
          rd_addr <= rd_addr - 1'b1;
          if (rd_addr == '0) lap <= ~lap;
        end
        2'b11: rd_addr <= man_addr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

  // Array is deliberately unreset; an aborted clear leaves it partly zeroed.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      clr_ptr <= '0;
    end else begin
      state   <= next_state;
      clr_ptr <= next_ptr;
    end
  end

  always_comb begin
    next_state = state;
    next_ptr   = clr_ptr;
    busy       = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    case (state)
      S_IDLE: begin
        mem_we = wr_en;
        if (clr_req) begin
          next_state = S_CLEAR;
          next_ptr   = '0;
        end
      end
      S_CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
        next_ptr  = clr_ptr + 1'b1;
        if (clr_ptr == ADDR_LAST) next_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Self-checking bench for ram_scan_ctrl: scan timing, lap wrap, manual reads,
// read-during-write, clear sequencing and mid-clear reset.
module tb_ram_scan_ctrl;

  localparam int DATA_W   = 4;
  localparam int ADDR_W   = 5;
  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] man_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              lap;
  logic              tick;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  ram_scan_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .mode     (mode),
    .man_addr (man_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .lap      (lap),
    .tick     (tick),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) check({tag, "_queue_empty"}, 32'd0, 32'd1);
    else check(tag, 32'(rd_data), 32'(exp_q.pop_front()));
  endtask

  // Returns at the negedge just after n tick-driven edges; bounded wait per tick.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      while (tick !== 1'b1 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      if (tick !== 1'b1) check("tick_timeout", 32'd0, 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic read_man(input logic [ADDR_W-1:0] a, input string tag);
    mode     = 2'b11;
    man_addr = a;
    exp_q.push_back(ref_mem[a]);
    @(negedge clk);
    check({tag, "_addr"}, 32'(rd_addr), 32'(a));
    @(negedge clk);
    pop_check(tag);
  endtask

  task automatic fill(input logic [DATA_W-1:0] v);
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(i);
      wr_data = v;
      ref_mem[i] = v;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    mode     = 2'b00;
    man_addr = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    clr_req  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_lap", 32'(lap), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Scan up from reset: tick on cycles 3, 7, 11; address steps after each.
    for (int i = 0; i < 12; i++) begin
      check($sformatf("up_tick_c%0d", i), 32'(tick), 32'((i % 4) == 3));
      check($sformatf("up_addr_c%0d", i), 32'(rd_addr), 32'(i / 4));
      @(negedge clk);
    end
    wait_ticks(29);
    check("wrap32_addr", 32'(rd_addr), 32'd0);
    check("wrap32_lap", 32'(lap), 32'd1);
    wait_ticks(32);
    check("wrap64_addr", 32'(rd_addr), 32'd0);
    check("wrap64_lap", 32'(lap), 32'd0);

    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(i);
      wr_data = DATA_W'(i * 3 + 1);
      ref_mem[i] = DATA_W'(i * 3 + 1);
      @(negedge clk);
    end
    wr_en = 1'b0;

    // Single write then manual read-back.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 4'hA; ref_mem[7] = 4'hA;
    @(negedge clk);
    wr_en = 1'b0;
    read_man(5'd7, "man7");
    read_man(5'd20, "man20");

    // Down scan wraps 0 -> 31 and toggles lap; hold keeps it while ticks continue.
    read_man(5'd0, "man0");
    mode = 2'b01;
    wait_ticks(1);
    check("down_wrap_addr", 32'(rd_addr), 32'd31);
    check("down_wrap_lap", 32'(lap), 32'd1);
    exp_q.push_back(ref_mem[31]);
    mode = 2'b10;
    @(negedge clk);
    pop_check("down_rd_data31");
    wait_ticks(10);
    check("hold_addr", 32'(rd_addr), 32'd31);
    check("hold_lap", 32'(lap), 32'd1);

    // Read-during-write on the manually addressed word.
    read_man(5'd5, "rdw_pre");
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 4'h3;
    exp_q.push_back(ref_mem[5]);
    ref_mem[5] = 4'h3;
    exp_q.push_back(ref_mem[5]);
    @(negedge clk);
    wr_en = 1'b0;
    pop_check("rdw_old");
    @(negedge clk);
    pop_check("rdw_new");

    // Full clear: exactly DEPTH busy cycles, mid-clear write dropped.
    fill(4'hF);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (n == 6) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 4'h9;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    wr_en = 1'b0;
    check("clear_busy_len", 32'(n), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 0; i < DEPTH; i++) read_man(ADDR_W'(i), $sformatf("clr_a%0d", i));

    // Reset while the clear pointer sits at 10.
    fill(4'hF);
    mode = 2'b11; man_addr = 5'd17;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midclr_rd_addr", 32'(rd_addr), 32'd0);
    check("midclr_rd_data", 32'(rd_data), 32'd0);
    check("midclr_lap", 32'(lap), 32'd0);
    check("midclr_tick", 32'(tick), 32'd0);
    check("midclr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) ref_mem[i] = '0;
    for (int i = 0; i < DEPTH; i++) read_man(ADDR_W'(i), $sformatf("part_a%0d", i));
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
